led_sequencer: RTL and testbench

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_pkg.sv | 19 +
 rtl/button_debounce.sv | 62 ++++++
 rtl/led_sequencer.sv | 120 ++++++++++++
 tb/tb_led_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared types for the LED sequencer.
// Holds the 2-bit display mode enum, the mode count and the mode-advance helper.
package led_pkg;

   typedef enum logic [1:0] {
      SHIFT_L = 2'd0,
      SHIFT_R = 2'd1,
      BOUNCE  = 2'd2,
      FILL    = 2'd3
   } mode_e;

   localparam int MODE_COUNT = 4;

   // Advance to the next mode, wrapping FILL back to SHIFT_L.
   function automatic mode_e next_mode(input mode_e m);
      return mode_e'(2'((int'(m) + 1) % MODE_COUNT));
   endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: conditions the asynchronous mode button.
// Two-flop synchroniser, then (when LED_SEQ_DEBOUNCE_EN is defined) a stability
// counter that only lets the filtered level change after DB_CYCLES consecutive
// cycles of disagreement. press is a one-cycle pulse on the conditioned 0->1 edge.
// Without LED_SEQ_DEBOUNCE_EN the synchronised level is used directly and no
// counter is built.
module button_debounce
   import led_pkg::*;
#(
   parameter int DB_CYCLES = 2_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   logic [1:0] sync_q;
   logic       level;
   logic       level_d;

   // Two-flop synchroniser; nothing downstream sees btn before sync_q[1].
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 2'b00;
      else     sync_q <= {sync_q[0], btn};
   end

`ifdef LED_SEQ_DEBOUNCE_EN
   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic [CW-1:0] db_cnt;
   logic          filt_q;

   // Stability window: count cycles where the input disagrees with the filtered level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt <= '0;
         filt_q <= 1'b0;
      end else if (sync_q[1] == filt_q) begin
         db_cnt <= '0;
      end else if (db_cnt == CW'(DB_CYCLES - 1)) begin
         filt_q <= sync_q[1];
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + CW'(1);
      end
   end

   assign level = filt_q;
`else
   assign level = sync_q[1];
`endif

   // Previous conditioned level, for rising-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) level_d <= 1'b0;
      else     level_d <= level;
   end

   assign press = level & ~level_d;

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: steps an N_LED-wide pattern every STEP_CYCLES clocks while run
// is high. The mode button cycles SHIFT_L -> SHIFT_R -> BOUNCE -> FILL.
// Optional build macro: LED_SEQ_DEBOUNCE_EN enables the button stability filter.
// led is always the decode of the next state, so a step or a mode change shows
// on the LEDs on the same edge that updates the state.
module led_sequencer
   import led_pkg::*;
#(
   parameter int N_LED       = 8,
   parameter int STEP_CYCLES = 100_000_000,
   parameter int DB_CYCLES   = 2_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             mode_btn,
   output logic [N_LED-1:0] led,
   output logic [1:0]       mode
);

   localparam int PW = $clog2(N_LED) + 1;
   localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [PW-1:0] POS_LAST   = PW'(N_LED - 1);
   localparam logic [PW-1:0] LEVEL_FULL = PW'(N_LED);
   localparam logic [SW-1:0] CNT_LAST   = SW'(STEP_CYCLES - 1);

   mode_e         mode_q, mode_n;
   logic [PW-1:0] pos_q, pos_n;
   logic [PW-1:0] level_q, level_n;
   logic          dir_q, dir_n;      // 0 = up, 1 = down (BOUNCE only)
   logic [SW-1:0] cnt_q, cnt_n;
   logic          press;
   logic          step;

   // Pattern decode: one-hot at pos for the moving modes, low 'lv' bits for FILL.
   function automatic logic [N_LED-1:0] pattern(input mode_e m,
                                                input logic [PW-1:0] p,
                                                input logic [PW-1:0] lv);
      logic [N_LED:0] fill;
      fill = ((N_LED + 1)'(1) << lv) - (N_LED + 1)'(1);
      if (m == FILL) return fill[N_LED-1:0];
      else           return N_LED'(1) << p;
   endfunction

   button_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .btn   (mode_btn),
      .press (press)
   );

   assign step = run && (cnt_q == CNT_LAST);

   // Next state: a press restarts everything and swallows any coincident step.
   always_comb begin
      mode_n  = mode_q;
      pos_n   = pos_q;
      level_n = level_q;
      dir_n   = dir_q;
      cnt_n   = cnt_q;
      if (press) begin
         mode_n  = next_mode(mode_q);
         pos_n   = '0;
         level_n = PW'(1);
         dir_n   = 1'b0;
         cnt_n   = '0;
      end else if (step) begin
         cnt_n = '0;
         case (mode_q)
            SHIFT_L: pos_n = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
            SHIFT_R: pos_n = (pos_q == '0) ? POS_LAST : pos_q - PW'(1);
            BOUNCE: begin
               if (!dir_q) begin
                  if (pos_q == POS_LAST) begin
                     pos_n = pos_q - PW'(1);
                     dir_n = 1'b1;
                  end else begin
                     pos_n = pos_q + PW'(1);
                  end
               end else begin
                  if (pos_q == '0) begin
                     pos_n = PW'(1);
                     dir_n = 1'b0;
                  end else begin
                     pos_n = pos_q - PW'(1);
                  end
               end
            end
            FILL:    level_n = (level_q == LEVEL_FULL) ? PW'(1) : level_q + PW'(1);
            default: pos_n = pos_q;
         endcase
      end else if (run) begin
         cnt_n = cnt_q + SW'(1);
      end
   end

   // State and LED register; led is cleared only while in reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q  <= SHIFT_L;
         pos_q   <= '0;
         level_q <= PW'(1);
         dir_q   <= 1'b0;
         cnt_q   <= '0;
         led     <= '0;
      end else begin
         mode_q  <= mode_n;
         pos_q   <= pos_n;
         level_q <= level_n;
         dir_q   <= dir_n;
         cnt_q   <= cnt_n;
         led     <= pattern(mode_n, pos_n, level_n);
      end
   end

   assign mode = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed table-driven bench for led_sequencer with
// N_LED=4, STEP_CYCLES=4, DB_CYCLES=3, plus hand-written sequences for the
// press/step collision, button glitches and reset during a press.
module tb_led_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic       mode_btn = 1'b0;
   logic [3:0] led;
   logic [1:0] mode;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef LED_SEQ_DEBOUNCE_EN
   localparam int PRESS_LAT = 6;
   localparam int RST_HOLD  = 4;
`else
   localparam int PRESS_LAT = 3;
   localparam int RST_HOLD  = 2;
`endif

   typedef struct {
      logic       press;
      logic       run;
      int         cycles;
      logic [3:0] exp_led;
      logic [1:0] exp_mode;
   } vec_t;

   vec_t vecs[$];

   led_sequencer #(
      .N_LED       (4),
      .STEP_CYCLES (4),
      .DB_CYCLES   (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .mode_btn (mode_btn),
      .led      (led),
      .mode     (mode)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic press_btn();
      mode_btn = 1'b1;
      repeat (8) tick();
      mode_btn = 1'b0;
      repeat (8) tick();
   endtask

   task automatic add(input logic p, input logic r, input int c,
                      input logic [3:0] l, input logic [1:0] m);
      vec_t v;
      v.press = p; v.run = r; v.cycles = c; v.exp_led = l; v.exp_mode = m;
      vecs.push_back(v);
   endtask

   initial begin
      logic seen;

      // SHIFT_L from reset release, including a 10-cycle run pause mid-step
      add(0, 1, 1, 4'b0001, 2'd0);
      add(0, 1, 3, 4'b0010, 2'd0);
      add(0, 1, 4, 4'b0100, 2'd0);
      add(0, 1, 4, 4'b1000, 2'd0);
      add(0, 1, 4, 4'b0001, 2'd0);
      add(0, 1, 2, 4'b0001, 2'd0);
      add(0, 0, 10, 4'b0001, 2'd0);
      add(0, 1, 1, 4'b0001, 2'd0);
      add(0, 1, 1, 4'b0010, 2'd0);
      add(0, 1, 4, 4'b0100, 2'd0);
      // SHIFT_R
      add(1, 0, 0, 4'b0001, 2'd1);
      add(0, 1, 3, 4'b0001, 2'd1);
      add(0, 1, 1, 4'b1000, 2'd1);
      add(0, 1, 4, 4'b0100, 2'd1);
      // BOUNCE
      add(1, 0, 0, 4'b0001, 2'd2);
      add(0, 1, 3, 4'b0001, 2'd2);
      add(0, 1, 1, 4'b0010, 2'd2);
      add(0, 1, 4, 4'b0100, 2'd2);
      add(0, 1, 4, 4'b1000, 2'd2);
      add(0, 1, 4, 4'b0100, 2'd2);
      add(0, 1, 4, 4'b0010, 2'd2);
      add(0, 1, 4, 4'b0001, 2'd2);
      add(0, 1, 4, 4'b0010, 2'd2);
      // mode wrap 3 -> 0, then three presses to FILL
      add(1, 0, 0, 4'b0001, 2'd3);
      add(1, 0, 0, 4'b0001, 2'd0);
      add(1, 0, 0, 4'b0001, 2'd1);
      add(1, 0, 0, 4'b0001, 2'd2);
      add(1, 0, 0, 4'b0001, 2'd3);
      add(0, 1, 3, 4'b0001, 2'd3);
      add(0, 1, 1, 4'b0011, 2'd3);
      add(0, 1, 4, 4'b0111, 2'd3);
      add(0, 1, 4, 4'b1111, 2'd3);
      add(0, 1, 4, 4'b0001, 2'd3);
      add(0, 1, 4, 4'b0011, 2'd3);
      add(1, 0, 0, 4'b0001, 2'd0);

      // reset state
      repeat (3) tick();
      check("reset_led", 32'(led), 32'h0);
      check("reset_mode", 32'(mode), 32'h0);
      rst = 1'b0;

      // table-driven vectors
      for (int i = 0; i < vecs.size(); i++) begin
         run = vecs[i].run;
         if (vecs[i].press) press_btn();
         repeat (vecs[i].cycles) tick();
         check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].exp_led));
         check($sformatf("vec%0d_mode", i), 32'(mode), 32'(vecs[i].exp_mode));
      end

      // press pulse lands on the same cycle as a step pulse: mode change wins
      run = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         tick();
         if (led != 4'b0001) seen = 1'b1;
      end
      check("align_step_seen", 32'(seen), 32'h1);
      repeat (8 - PRESS_LAT) tick();
      mode_btn = 1'b1;
      repeat (PRESS_LAT - 1) tick();
      check("align_pre_led", 32'(led), 32'h4);
      check("align_pre_mode", 32'(mode), 32'h0);
      tick();
      check("align_led", 32'(led), 32'h1);
      check("align_mode", 32'(mode), 32'h1);
      repeat (3) tick();
      check("align_hold_led", 32'(led), 32'h1);
      tick();
      check("align_next_led", 32'(led), 32'h8);
      run = 1'b0;
      mode_btn = 1'b0;
      repeat (8) tick();
      check("align_release_mode", 32'(mode), 32'h1);

`ifdef LED_SEQ_DEBOUNCE_EN
      // 2-cycle glitch is filtered out
      mode_btn = 1'b1;
      repeat (2) tick();
      mode_btn = 1'b0;
      repeat (10) tick();
      check("glitch_mode", 32'(mode), 32'h1);
      // 5-cycle press gives exactly one change
      mode_btn = 1'b1;
      repeat (5) tick();
      mode_btn = 1'b0;
      repeat (10) tick();
      check("press5_mode", 32'(mode), 32'h2);
      check("press5_led", 32'(led), 32'h1);
`endif

      // reset asserted part-way through a press, button released during reset
      mode_btn = 1'b1;
      repeat (RST_HOLD) tick();
      rst = 1'b1;
      #1;
      check("midpress_rst_led", 32'(led), 32'h0);
      check("midpress_rst_mode", 32'(mode), 32'h0);
      mode_btn = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      repeat (10) tick();
      check("after_rst_mode", 32'(mode), 32'h0);
      check("after_rst_led", 32'(led), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
